debug_inst_loader: RTL and testbench

DEBUG_INST_LOADER -- requirements
Module: debug_inst_loader

---
 rtl/debug_inst_loader_if.sv | 29 ++
 rtl/debug_inst_loader.sv | 110 +++++++++++
 tb/tb_debug_inst_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_inst_loader_if.sv
// Byte-stream loader bus: start/received-byte inputs and instruction-memory
// write port with load status, shared by the loader and its controller.
interface debug_inst_loader_if #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 8
);
  logic               i_start;
  logic               i_rx_valid;
  logic [7:0]         i_rx_data;
  logic               o_debug_unit;
  logic               o_mem_wen;
  logic [NB_INST-1:0] o_mem_data;
  logic [NB_ADDR-1:0] o_wr_addr;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;

  modport master (
    output i_start, i_rx_valid, i_rx_data,
    input  o_debug_unit, o_mem_wen, o_mem_data, o_wr_addr,
           o_done, o_overflow, o_word_count
  );

  modport slave (
    input  i_start, i_rx_valid, i_rx_data,
    output o_debug_unit, o_mem_wen, o_mem_data, o_wr_addr,
           o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/debug_inst_loader.sv
// Assembles big-endian bytes into instruction words and writes them to
// instruction memory until the halt word or the end of memory is reached.
module debug_inst_loader #(
  parameter int                 NB_INST   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFC000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  debug_inst_loader_if.slave bus
);

  localparam int NB_BYTES = NB_INST / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   byte_idx;
  logic [NB_INST-1:0] asm_word;
  logic [NB_ADDR-1:0] addr;
  logic [NB_ADDR:0]   word_count;
  logic               debug_unit;
  logic               mem_wen;
  logic [NB_INST-1:0] mem_data;
  logic [NB_ADDR-1:0] wr_addr;
  logic               done;
  logic               overflow;

  // First received byte ends up in the most significant byte of the word.
  function automatic logic [NB_INST-1:0] shift_in(input logic [NB_INST-1:0] w,
                                                  input logic [7:0]         b);
    return {w[NB_INST-9:0], b};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      byte_idx   <= '0;
      asm_word   <= '0;
      addr       <= '0;
      word_count <= '0;
      debug_unit <= 1'b0;
      mem_wen    <= 1'b0;
      mem_data   <= '0;
      wr_addr    <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state      <= RECV;
            byte_idx   <= '0;
            asm_word   <= '0;
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            debug_unit <= 1'b1;
          end
        end
        RECV: begin
          // Byte capture runs independently of the write bookkeeping below,
          // so a byte arriving during the strobe cycle is kept.
          if (bus.i_rx_valid) begin
            asm_word <= shift_in(asm_word, bus.i_rx_data);
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              mem_wen  <= 1'b1;
              mem_data <= shift_in(asm_word, bus.i_rx_data);
              wr_addr  <= addr;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          if (mem_wen) begin
            addr       <= addr + 1'b1;
            word_count <= word_count + 1'b1;
            if (mem_data == HALT_WORD) begin
              state      <= DONE;
              done       <= 1'b1;
              debug_unit <= 1'b0;
              overflow   <= 1'b0;
            end else if (wr_addr == LAST_ADDR) begin
              state      <= DONE;
              done       <= 1'b1;
              debug_unit <= 1'b0;
              overflow   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_debug_unit = debug_unit;
  assign bus.o_mem_wen    = mem_wen;
  assign bus.o_mem_data   = mem_data;
  assign bus.o_wr_addr    = wr_addr;
  assign bus.o_done       = done;
  assign bus.o_overflow   = overflow;
  assign bus.o_word_count = word_count;

endmodule

// File: tb/tb_debug_inst_loader.sv
// Directed bench for debug_inst_loader: one full-depth instance and one
// four-word instance for the memory-full paths.
module tb_debug_inst_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_inst_loader_if #(.NB_INST(32), .NB_ADDR(8)) a ();
  debug_inst_loader_if #(.NB_INST(32), .NB_ADDR(8)) b ();

  debug_inst_loader #(.NB_INST(32), .NB_ADDR(8), .MEM_DEPTH(256),
                      .HALT_WORD(32'hFC000000))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(a.slave));

  debug_inst_loader #(.NB_INST(32), .NB_ADDR(8), .MEM_DEPTH(4),
                      .HALT_WORD(32'hFC000000))
    dut_b (.i_clk(clk), .i_reset(rst), .bus(b.slave));

  int   total = 0;
  int   bad   = 0;
  logic use_b = 1'b0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic v, input logic [7:0] d);
    if (use_b) begin
      b.i_start = st; b.i_rx_valid = v; b.i_rx_data = d;
    end else begin
      a.i_start = st; a.i_rx_valid = v; a.i_rx_data = d;
    end
  endtask

  task automatic sendb(input logic [7:0] d);
    drv(1'b0, 1'b1, d);
    tick();
    drv(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sendb(w[31-8*i -: 8]);
  endtask

  task automatic pulse_start();
    drv(1'b1, 1'b0, 8'h00);
    tick();
    drv(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] bb [8];

  initial begin
    rst = 1'b1;
    use_b = 1'b1; drv(1'b0, 1'b0, 8'h00);
    use_b = 1'b0; drv(1'b0, 1'b0, 8'h00);
    tick(); tick();
    chk("rst_debug", a.o_debug_unit, 0);
    chk("rst_wen",   a.o_mem_wen,    0);
    chk("rst_data",  a.o_mem_data,   0);
    chk("rst_addr",  a.o_wr_addr,    0);
    chk("rst_done",  a.o_done,       0);
    chk("rst_ovf",   a.o_overflow,   0);
    chk("rst_count", a.o_word_count, 0);
    chk("rst_b_done", b.o_done,      0);
    rst = 1'b0;

    // bytes with no start are ignored
    send_word(32'h11223344);
    chk("idle_wen", a.o_mem_wen, 0);
    tick();
    chk("idle_addr",  a.o_wr_addr,    0);
    chk("idle_count", a.o_word_count, 0);
    chk("idle_debug", a.o_debug_unit, 0);

    // first word
    pulse_start();
    chk("start_debug", a.o_debug_unit, 1);
    chk("start_done",  a.o_done,       0);
    send_word(32'h3C01000A);
    chk("w0_wen",  a.o_mem_wen,  1);
    chk("w0_data", a.o_mem_data, 64'h3C01000A);
    chk("w0_addr", a.o_wr_addr,  0);
    tick();
    chk("w0_wen_off", a.o_mem_wen,    0);
    chk("w0_count",   a.o_word_count, 1);
    chk("w0_hold",    a.o_mem_data,   64'h3C01000A);

    // start while receiving is ignored
    pulse_start();
    chk("rstart_count", a.o_word_count, 1);
    chk("rstart_debug", a.o_debug_unit, 1);

    for (int i = 1; i <= 9; i++) begin
      send_word(32'(i));
      chk("prog_wen",  a.o_mem_wen,  1);
      chk("prog_addr", a.o_wr_addr,  64'(i));
      chk("prog_data", a.o_mem_data, 64'(i));
      tick();
    end
    send_word(32'hFC000000);
    chk("halt_wen",  a.o_mem_wen,  1);
    chk("halt_addr", a.o_wr_addr,  10);
    chk("halt_data", a.o_mem_data, 64'hFC000000);
    tick();
    chk("halt_done",  a.o_done,       1);
    chk("halt_ovf",   a.o_overflow,   0);
    chk("halt_debug", a.o_debug_unit, 0);
    chk("halt_count", a.o_word_count, 11);

    // bytes in DONE are ignored
    send_word(32'h12345678);
    chk("done_wen", a.o_mem_wen, 0);
    tick();
    chk("done_count", a.o_word_count, 11);
    chk("done_hold",  a.o_done,       1);

    // restart from DONE, bytes back-to-back including the strobe cycle
    pulse_start();
    chk("re_done",  a.o_done,       0);
    chk("re_debug", a.o_debug_unit, 1);
    chk("re_count", a.o_word_count, 0);
    bb = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int k = 0; k < 8; k++) begin
      drv(1'b0, 1'b1, bb[k]);
      tick();
      if (k == 3) begin
        chk("b2b_wen0",  a.o_mem_wen,  1);
        chk("b2b_data0", a.o_mem_data, 1);
        chk("b2b_addr0", a.o_wr_addr,  0);
      end
      if (k == 4) chk("b2b_gap", a.o_mem_wen, 0);
      if (k == 7) begin
        chk("b2b_wen1",  a.o_mem_wen,  1);
        chk("b2b_data1", a.o_mem_data, 2);
        chk("b2b_addr1", a.o_wr_addr,  1);
      end
    end
    drv(1'b0, 1'b0, 8'h00);
    tick();
    chk("b2b_count", a.o_word_count, 2);

    // reset mid-word, colliding with the final byte and a start
    sendb(8'hAA); sendb(8'hBB); sendb(8'hCC);
    rst = 1'b1;
    drv(1'b1, 1'b1, 8'hDD);
    tick();
    chk("mid_rst_wen",   a.o_mem_wen,    0);
    chk("mid_rst_data",  a.o_mem_data,   0);
    chk("mid_rst_count", a.o_word_count, 0);
    chk("mid_rst_debug", a.o_debug_unit, 0);
    rst = 1'b0;
    drv(1'b0, 1'b0, 8'h00);
    tick();
    chk("post_rst_wen",   a.o_mem_wen,    0);
    chk("post_rst_debug", a.o_debug_unit, 0);
    pulse_start();
    send_word(32'h2003000A);
    chk("after_rst_wen",  a.o_mem_wen,  1);
    chk("after_rst_data", a.o_mem_data, 64'h2003000A);
    chk("after_rst_addr", a.o_wr_addr,  0);
    tick();
    chk("after_rst_count", a.o_word_count, 1);

    // four-word memory: fill without halt
    use_b = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_word(32'hA0000000 + 32'(i));
      chk("full_wen",  b.o_mem_wen, 1);
      chk("full_addr", b.o_wr_addr, 64'(i));
      tick();
    end
    chk("full_done",  b.o_done,       1);
    chk("full_ovf",   b.o_overflow,   1);
    chk("full_debug", b.o_debug_unit, 0);
    chk("full_count", b.o_word_count, 4);
    send_word(32'hA0000004);
    chk("full_extra_wen", b.o_mem_wen, 0);
    tick();
    chk("full_extra_count", b.o_word_count, 4);

    // halt landing on the last address
    pulse_start();
    chk("lasth_ovf_clr", b.o_overflow, 0);
    for (int i = 0; i < 3; i++) begin
      send_word(32'hB0000000 + 32'(i));
      tick();
    end
    send_word(32'hFC000000);
    chk("lasth_wen",  b.o_mem_wen, 1);
    chk("lasth_addr", b.o_wr_addr, 3);
    tick();
    chk("lasth_done",  b.o_done,       1);
    chk("lasth_ovf",   b.o_overflow,   0);
    chk("lasth_count", b.o_word_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
